// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: operation codes,
// exception codes and the load/store classification helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    LW  = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LB  = 4'd4,
    LBU = 4'd5,
    SW  = 4'd6,
    SH  = 4'd7,
    SB  = 4'd8
  } mem_op_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  function automatic logic is_load(input mem_op_e op);
    return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/halfword out of the read word and extends it to
// 32 bits (sign for LB/LH, zero for LBU/LHU); LW passes the word through.
module load_extend (
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);
  import mem_pkg::*;

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Lane selection and extension of the loaded value
  always_comb begin
    byte_s = '0;
    half_s = '0;
    data   = '0;
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = lane[1] ? word[31:16] : word[15:0];
    case (mem_op_e'(op))
      LW:      data = word;
      LH:      data = 32'(half_s);
      LHU:     data = {16'h0000, half_s};
      LB:      data = 32'(byte_s);
      LBU:     data = {24'h000000, byte_s};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Stage A (_p1) holds the request and drives the
// data memory; stage B (_p2) holds the extended load result or exception.
module mem_access_unit #(
  parameter int         ADDR_W   = 32,
  parameter logic [4:0] EXC_ADEL = 5'd4,
  parameter logic [4:0] EXC_ADES = 5'd5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_rd,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_byteen,
  output logic              dm_we,
  output logic [31:0]       dm_pc,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic [31:0]       wb_pc,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [ADDR_W-1:0] exc_addr,
  output logic [31:0]       exc_pc
);
  import mem_pkg::*;

  function automatic logic misaligned(input mem_op_e op, input logic [1:0] lsb);
    case (op)
      LW, SW:      return lsb != 2'b00;
      LH, LHU, SH: return lsb[0];
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input mem_op_e op, input logic [1:0] lsb);
    case (op)
      SW:      return 4'b1111;
      SH:      return lsb[1] ? 4'b1100 : 4'b0011;
      SB:      return 4'b0001 << lsb;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input mem_op_e op, input logic [31:0] w);
    case (op)
      SH:      return {2{w[15:0]}};
      SB:      return {4{w[7:0]}};
      default: return w;
    endcase
  endfunction

  // ---- stage A: memory access ----
  logic              vld_p1;
  mem_op_e           op_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;
  logic [31:0]       pc_p1;
  logic [4:0]        rd_p1;

  // Capture the incoming request; flush or an idle input loads a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      op_p1    <= NOP;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      pc_p1    <= '0;
      rd_p1    <= '0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      op_p1    <= NOP;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      pc_p1    <= '0;
      rd_p1    <= '0;
    end else if (!stall) begin
      vld_p1   <= in_valid;
      op_p1    <= in_valid ? mem_op_e'(in_op) : NOP;
      addr_p1  <= in_addr;
      wdata_p1 <= in_wdata;
      pc_p1    <= in_pc;
      rd_p1    <= in_rd;
    end
  end

  logic        load_p1;
  logic        store_p1;
  logic        mis_p1;
  logic        take_p1;
  logic        ld_ok_p1;
  logic [31:0] ext_p1;

  assign load_p1  = is_load(op_p1);
  assign store_p1 = is_store(op_p1);
  assign mis_p1   = misaligned(op_p1, addr_p1[1:0]);
  // An entry only moves on to stage B if it was not killed this cycle
  assign take_p1  = vld_p1 & ~flush;
  assign ld_ok_p1 = take_p1 & load_p1 & ~mis_p1;

  // The write strobe is purely combinational off stage A so that an async
  // reset (which clears vld_p1) drops it immediately; a stalled store waits
  // for its advancing cycle so each store writes exactly once.
  assign dm_addr   = addr_p1;
  assign dm_pc     = pc_p1;
  assign dm_byteen = byte_enables(op_p1, addr_p1[1:0]);
  assign dm_wdata  = replicate(op_p1, wdata_p1);
  assign dm_we     = vld_p1 & store_p1 & ~mis_p1 & ~stall & ~flush;

  load_extend u_load_extend (
    .op   (op_p1),
    .lane (addr_p1[1:0]),
    .word (dm_rdata),
    .data (ext_p1)
  );

  // ---- stage B: writeback ----
  logic              vld_p2;
  logic              regwrite_p2;
  logic [4:0]        rd_p2;
  logic [31:0]       data_p2;
  logic [31:0]       pc_p2;
  logic              exc_p2;
  logic [4:0]        code_p2;
  logic [ADDR_W-1:0] eaddr_p2;
  logic [31:0]       epc_p2;

  // Register the processed stage-A entry: load result or alignment fault
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2      <= 1'b0;
      regwrite_p2 <= 1'b0;
      rd_p2       <= '0;
      data_p2     <= '0;
      pc_p2       <= '0;
      exc_p2      <= 1'b0;
      code_p2     <= '0;
      eaddr_p2    <= '0;
      epc_p2      <= '0;
    end else if (!stall) begin
      vld_p2      <= take_p1;
      regwrite_p2 <= ld_ok_p1;
      rd_p2       <= rd_p1;
      data_p2     <= ld_ok_p1 ? ext_p1 : '0;
      pc_p2       <= pc_p1;
      exc_p2      <= take_p1 & mis_p1;
      code_p2     <= (take_p1 & mis_p1) ? (load_p1 ? EXC_ADEL : EXC_ADES) : 5'd0;
      eaddr_p2    <= (take_p1 & mis_p1) ? addr_p1 : '0;
      epc_p2      <= (take_p1 & mis_p1) ? pc_p1 : '0;
    end
  end

  assign wb_valid    = vld_p2;
  assign wb_regwrite = regwrite_p2;
  assign wb_rd       = rd_p2;
  assign wb_data     = data_p2;
  assign wb_pc       = pc_p2;
  assign exc_valid   = exc_p2;
  assign exc_code    = code_p2;
  assign exc_addr    = eaddr_p2;
  assign exc_pc      = epc_p2;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected memory
// writes and writeback entries; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic [3:0]  dm_byteen;
  logic        dm_we;
  logic        wb_valid, wb_regwrite, exc_valid;
  logic [4:0]  wb_rd, exc_code;
  logic [31:0] wb_data, wb_pc, exc_addr, exc_pc;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_pc(in_pc), .in_rd(in_rd),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_byteen(dm_byteen), .dm_we(dm_we),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr),
    .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  // Small byte-enabled data memory with a combinational read port
  logic [31:0] mem [0:63];
  assign dm_rdata = mem[dm_addr[7:2]];
  always @(posedge clk) begin
    if (dm_we)
      for (int i = 0; i < 4; i++)
        if (dm_byteen[i]) mem[dm_addr[7:2]][8*i +: 8] <= dm_wdata[8*i +: 8];
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [3:0]  be;
  } dm_exp_t;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic        chk_data;
    logic [31:0] data;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] eaddr;
  } wb_exp_t;

  dm_exp_t dm_q[$];
  wb_exp_t wb_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int seq = 0;
  logic b_adv = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] all_outs();
    return {dm_addr, dm_wdata, dm_byteen, dm_we, dm_pc, wb_valid, wb_regwrite, wb_rd,
            wb_data, wb_pc, exc_valid, exc_code, exc_addr, exc_pc};
  endfunction

  // Present one request for one edge; optionally record its expected effects
  task automatic issue(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic push, input logic wr, input logic [31:0] exp_wd,
                       input logic [3:0] exp_be, input logic rw, input logic chkd,
                       input logic [31:0] exp_data, input logic exc, input logic [4:0] code);
    logic [31:0] pc;
    logic [4:0]  rd;
    seq++;
    pc = 32'h1000 + 32'(seq * 4);
    rd = 5'(seq);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_pc = pc; in_rd = rd;
    if (push) begin
      if (wr) dm_q.push_back('{addr: addr, wdata: exp_wd, pc: pc, be: exp_be});
      wb_q.push_back('{rw: rw, rd: rd, chk_data: chkd, data: exp_data, pc: pc,
                       exc: exc, code: code, eaddr: addr});
    end
    @(posedge clk); #2;
    in_valid = 1'b0; in_op = NOP;
  endtask

  // Monitor: compare every memory write and every newly arrived stage-B entry
  initial begin : monitor
    dm_exp_t de;
    wb_exp_t we;
    forever begin
      @(posedge clk);
      b_adv = !stall && reset;
      @(negedge clk);
      if (dm_we) begin
        if (dm_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dm_unexpected_write: addr %0h data %0h be %b", dm_addr, dm_wdata, dm_byteen);
        end else begin
          de = dm_q.pop_front();
          chk("dm_addr", dm_addr, de.addr);
          chk("dm_wdata", dm_wdata, de.wdata);
          chk("dm_byteen", dm_byteen, de.be);
          chk("dm_pc", dm_pc, de.pc);
        end
      end
      if (b_adv && wb_valid) begin
        if (wb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL wb_unexpected: pc %0h rd %0d", wb_pc, wb_rd);
        end else begin
          we = wb_q.pop_front();
          chk("wb_regwrite", wb_regwrite, we.rw);
          chk("wb_rd", wb_rd, we.rd);
          chk("wb_pc", wb_pc, we.pc);
          chk("exc_valid", exc_valid, we.exc);
          if (we.chk_data) chk("wb_data", wb_data, we.data);
          if (we.exc) begin
            chk("exc_code", exc_code, we.code);
            chk("exc_addr", exc_addr, we.eaddr);
            chk("exc_pc", exc_pc, we.pc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #3;
    chk("reset_outputs_zero", all_outs(), '0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("post_reset_dm_we", dm_we, 1'b0);
    @(posedge clk); #2;

    // op, addr, wdata, push, wr, exp_wd, exp_be, rw, chkd, exp_data, exc, code
    issue(SW,  32'h10, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0, 0);
    issue(LW,  32'h10, 32'h0,        1, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0);
    issue(SB,  32'h13, 32'h000000A5, 1, 1, 32'hA5A5A5A5, 4'b1000, 0, 0, 0, 0, 0);
    issue(SH,  32'h12, 32'h00001234, 1, 1, 32'h12341234, 4'b1100, 0, 0, 0, 0, 0);
    issue(SW,  32'h10, 32'h80F07F01, 1, 1, 32'h80F07F01, 4'b1111, 0, 0, 0, 0, 0);
    issue(LB,  32'h12, 32'h0,        1, 0, 0, 0, 1, 1, 32'hFFFFFFF0, 0, 0);
    issue(LBU, 32'h12, 32'h0,        1, 0, 0, 0, 1, 1, 32'h000000F0, 0, 0);
    issue(LH,  32'h12, 32'h0,        1, 0, 0, 0, 1, 1, 32'hFFFF80F0, 0, 0);
    issue(LHU, 32'h10, 32'h0,        1, 0, 0, 0, 1, 1, 32'h00007F01, 0, 0);
    issue(LB,  32'h11, 32'h0,        1, 0, 0, 0, 1, 1, 32'h0000007F, 0, 0);
    issue(LW,  32'h22, 32'h0,        1, 0, 0, 0, 0, 0, 0, 1, 5'd4);
    issue(SH,  32'h21, 32'h0000BEEF, 1, 0, 0, 0, 0, 0, 0, 1, 5'd5);
    issue(NOP, 32'h0,  32'h0,        1, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    repeat (2) begin @(posedge clk); #2; end

    // Store held by a three-cycle stall writes exactly once on release
    issue(SW,  32'h30, 32'h11223344, 1, 1, 32'h11223344, 4'b1111, 0, 0, 0, 0, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_dm_we_low", dm_we, 1'b0);
      @(posedge clk); #2;
    end
    stall = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    chk("after_release_dm_we_low", dm_we, 1'b0);
    @(posedge clk); #2;

    // Store flushed while stalled never writes and never reaches writeback
    issue(SW,  32'h34, 32'h55667788, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_dm_we_low", dm_we, 1'b0);
    @(posedge clk); #2;
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("post_flush_dm_we_low", dm_we, 1'b0);
    repeat (2) begin @(posedge clk); #2; end
    chk("flushed_word_untouched", (mem[13] === 32'h55667788), 1'b0);

    // Asynchronous reset while a store is in stage A
    issue(SW,  32'h38, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_dm_we_high", dm_we, 1'b1);
    #1 reset = 1'b0;
    #1 chk("async_reset_dm_we", dm_we, 1'b0);
    chk("async_reset_outputs_zero", all_outs(), '0);
    repeat (2) begin
      @(negedge clk);
      chk("in_reset_outputs_zero", all_outs(), '0);
    end
    @(posedge clk); #2 reset = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    chk("reset_store_not_written", (mem[14] === 32'hCAFEF00D), 1'b0);

    chk("dm_queue_drained", 32'(dm_q.size()), 32'd0);
    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit. It sits between the EX/MEM pipeline register and the data memory.
- On the store side it registers the memory request, checks alignment, generates the per-lane byte enables, and replicates the store data across lanes before driving the data memory.
- On the load side it captures the memory's combinational read word and extracts and sign/zero-extends the addressed byte or halfword into a registered writeback stage.
- It is a two-stage pipeline (A = memory access, B = writeback) with stall and flush control.

Parameters:
- ADDR_W, 32, address width.
- EXC_ADEL, 5'd4, exception code for a misaligned load.
- EXC_ADES, 5'd5, exception code for a misaligned store.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- stall  in  1  hold stage A and stage B.
- flush  in  1  kill the stage-A entry.
- in_valid  in  1  request present.
- in_op  in  4  operation code, from the shared package.
- in_addr  in  32  byte address.
- in_wdata  in  32  store data, right-aligned.
- in_pc  in  32  instruction PC.
- in_rd  in  5  destination register.
- dm_addr  out  32  stage-A address.
- dm_wdata  out  32  lane-replicated store data.
- dm_byteen  out  4  bit i enables byte lane i.
- dm_we  out  1  memory write strobe.
- dm_pc  out  32  PC of the writing instruction.
- dm_rdata  in  32  combinational read word for dm_addr.
- wb_valid  out  1  stage-B entry valid.
- wb_regwrite  out  1  asserted for a valid, non-faulting load.
- wb_rd  out  5  destination register.
- wb_data  out  32  extended load data.
- wb_pc  out  32  PC of the stage-B entry.
- exc_valid  out  1  stage-B entry faulted.
- exc_code  out  5  exception code.
- exc_addr  out  32  faulting address.
- exc_pc  out  32  faulting PC.

Behaviour:
- Reset (asynchronous, reset=0):
  - Stage-A and stage-B valid bits clear.
  - All stage registers clear to 0.
  - Consequently dm_we=0, dm_byteen=0, wb_valid=0, wb_regwrite=0, exc_valid=0, and all data outputs are 0.
  - A reset asserted mid-operation drops dm_we in the same cycle; no partial write is issued.
- Stage A load (no stall):
  - Stage A loads in_* at the clock edge; in_valid=0 loads a bubble.
  - flush=1 forces a bubble into stage A regardless of stall.
- Stage B load (no stall): stage B loads the processed stage-A contents.
- stall=1: both stages hold their contents.
- Latency: the request is accepted at edge N, drives the data memory during cycle N, and appears on wb_* after edge N+1.
- Alignment (stage A, combinational):
  - LW/SW require addr[1:0]=0.
  - LH/LHU/SH require addr[0]=0.
  - Byte ops and NOP never fault.
  - A faulting store drives dm_we=0.
  - A faulting entry reaches stage B with exc_valid=1, exc_code = EXC_ADEL (load) or EXC_ADES (store), and wb_regwrite=0.
- Byte enables:
  - SW: 1111.
  - SH: 0011 if addr[1]=0, else 1100.
  - SB: 0001 shifted left by addr[1:0].
  - All other ops: 0000.
- Store data:
  - SW: unchanged.
  - SH: {h,h}, where h = wdata[15:0].
  - SB: {b,b,b,b}, where b = wdata[7:0].
- dm_addr = stage-A address, unmodified.
- dm_we = A_valid & store & aligned & ~stall & ~flush. Each store is written exactly once, in its advancing cycle.
- Load extraction from dm_rdata, captured into stage B at the advancing edge:
  - Byte lane = addr[1:0].
  - Halfword = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- NOP entries pass to stage B with wb_regwrite=0 and wb_data=0.
- Simultaneous stall and flush: stage A is bubbled, stage B holds.

Decomposition:
- Shared package, mem_pkg, holds:
  - Op codes: NOP=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8.
  - EXC_ADEL and EXC_ADES.
  - is_load and is_store helper functions.
- One natural combinational sub-module, load_extend: op, addr[1:0] and word in, 32-bit extended data out.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF → next cycle dm_we=1, dm_byteen=1111, dm_wdata=0xDEADBEEF; then LW 0x10 with dm_rdata=0xDEADBEEF → wb_data=0xDEADBEEF, wb_regwrite=1, two edges after accept.
- SB addr=0x13 wdata=0x000000A5 → dm_byteen=1000, dm_wdata=0xA5A5A5A5.
- dm_rdata=0x80F07F01:
  - LB 0x12 → 0xFFFFFFF0.
  - LBU 0x12 → 0x000000F0.
  - LH 0x12 → 0xFFFF80F0.
  - LHU 0x10 → 0x00007F01.
- LW addr=0x22 → dm_we=0; stage B shows exc_valid=1, exc_code=4, exc_addr=0x22, wb_regwrite=0. SH addr=0x21 → exc_code=5, and no write occurs.
- SW held under stall=1 for 3 cycles → dm_we stays 0 throughout; on stall release, dm_we=1 for exactly one cycle. flush=1 during the stall → the store never writes.
- Assert reset=0 mid-cycle while stage A holds SW → dm_we falls immediately without a clock edge; all outputs read 0 until reset=1.
